// File: rtl/dual_edge_detector_mealy.sv
// Two-state Mealy edge detector: y/rise/fall flag any change of x vs. the last sampled level.
// Optional input synchronizer enabled by defining DUAL_EDGE_SYNC_EN (depth SYNC_STAGES, 2..4).
module dual_edge_detector_mealy #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic y,
    output logic rise,
    output logic fall
);

    typedef enum logic {
        ZERO = 1'b0,
        ONE  = 1'b1
    } state_t;

    state_t state;
    logic   x_det;

`ifdef DUAL_EDGE_SYNC_EN
    logic [SYNC_STAGES-1:0] sync;

    // Shift x through the synchronizer chain; cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], x};
        end
    end

    assign x_det = sync[SYNC_STAGES-1];
`else
    logic unused_cfg;

    // Depth only matters when the synchronizer is built.
    assign unused_cfg = SYNC_STAGES[0];
    assign x_det      = x;
`endif

    // Remember the last sampled level; reset forces ZERO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ZERO;
        end else begin
            unique case (state)
                ZERO:    state <= x_det ? ONE : ZERO;
                ONE:     state <= x_det ? ONE : ZERO;
                default: state <= ZERO;
            endcase
        end
    end

    // Mealy outputs: any disagreement between level and stored state is an edge.
    always_comb begin
        y    = 1'b0;
        rise = 1'b0;
        fall = 1'b0;
        if (!reset) begin
            unique case (state)
                ZERO:    y = x_det;
                ONE:     y = ~x_det;
                default: y = 1'b0;
            endcase
            rise = y & x_det;
            fall = y & ~x_det;
        end
    end

endmodule

// File: tb/tb_dual_edge_detector_mealy.sv
// Self-checking bench for dual_edge_detector_mealy.
// Reference model tracks the last sampled level and compares every cycle.
module tb_dual_edge_detector_mealy;

    localparam int SS = 2;

    logic clk;
    logic reset;
    logic x;
    logic y;
    logic rise;
    logic fall;

    int checks;
    int failures;

    dual_edge_detector_mealy #(.SYNC_STAGES(SS)) dut (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .y     (y),
        .rise  (rise),
        .fall  (fall)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Model: previous level seen at a rising edge, and the level the detector observes.
    logic m_prev = 1'b0;
    logic m_pipe [SS] = '{default: 1'b0};

    function automatic logic m_level();
`ifdef DUAL_EDGE_SYNC_EN
        return m_pipe[SS-1];
`else
        return x;
`endif
    endfunction

    always @(posedge clk) begin
        logic lv;
        lv = m_level();
        if (reset) begin
            m_prev <= 1'b0;
            for (int i = 0; i < SS; i++) m_pipe[i] <= 1'b0;
        end else begin
            m_prev    <= lv;
            m_pipe[0] <= x;
            for (int i = 1; i < SS; i++) m_pipe[i] <= m_pipe[i-1];
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: 5 ns before each rising edge.
    always @(negedge clk) begin
        logic lv;
        logic ey;
        #5;
        lv = m_level();
        ey = !reset && (lv != m_prev);
        chk("model_y", y, ey);
        chk("model_rise", rise, ey && lv);
        chk("model_fall", fall, ey && !lv);
    end

    task automatic step(input logic xv);
        @(negedge clk);
        x = xv;
        #8;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        x        = 1'b1;

`ifndef DUAL_EDGE_SYNC_EN
        // Reset held with x=1: outputs forced low.
        repeat (3) step(1'b1);
        chk("rst_y", y, 1'b0);
        chk("rst_rise", rise, 1'b0);
        chk("rst_fall", fall, 1'b0);

        // Release with x=1: immediate rise, gone after next edge.
        @(negedge clk);
        reset = 1'b0;
        #8;
        chk("rel_y", y, 1'b1);
        chk("rel_rise", rise, 1'b1);
        chk("rel_fall", fall, 1'b0);
        step(1'b1);
        chk("rel_y_next", y, 1'b0);

        // One toggle per cycle: y stays high, rise/fall alternate.
        for (int i = 0; i < 20; i++) begin
            step(~x);
            chk("tog_y", y, 1'b1);
            chk("tog_rise", rise, x);
            chk("tog_fall", fall, ~x);
        end

        // 0 then 1 each 20 ns, 20 times.
        for (int i = 0; i < 40; i++) begin
            step(i[0]);
            chk("alt_y", y, 1'b1);
            chk("alt_rise", rise, i[0]);
            chk("alt_fall", fall, ~i[0]);
        end

        // Constant x for 5 cycles: no indication.
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            chk("const_y", y, 1'b0);
        end

        // Settle at ZERO, then a glitch inside the low phase.
        step(1'b0);
        chk("to_zero_fall", fall, 1'b1);
        step(1'b0);
        chk("zero_y", y, 1'b0);
        @(negedge clk);
        #2 x = 1'b1;
        #2;
        chk("glitch_y", y, 1'b1);
        chk("glitch_rise", rise, 1'b1);
        #2 x = 1'b0;
        #2;
        chk("glitch_end_y", y, 1'b0);
        step(1'b0);
        chk("glitch_state_y", y, 1'b0);

        // Reset during an edge indication.
        @(negedge clk);
        x = 1'b1;
        #2;
        chk("pre_rst_y", y, 1'b1);
        #2 reset = 1'b1;
        #2;
        chk("mid_rst_y", y, 1'b0);
        chk("mid_rst_rise", rise, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        x = 1'b1;
        #8;
        chk("post_rst_zero_y", y, 1'b1);
`else
        repeat (3) step(1'b0);
        @(negedge clk);
        reset = 1'b0;
        #8;
        step(1'b0);
        step(1'b1);
        chk("sync_c0_y", y, 1'b0);
        step(1'b1);
        chk("sync_c1_y", y, 1'b0);
        step(1'b1);
        chk("sync_c2_y", y, 1'b1);
        chk("sync_c2_rise", rise, 1'b1);
        step(1'b1);
        chk("sync_c3_y", y, 1'b0);
`endif

        // Pseudo-random tail checked by the model only.
        for (int i = 0; i < 30; i++) begin
            step(1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        #8;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
